// File: rtl/lif_scheduler.sv
// lif_scheduler: prescaled tick source driving a time-multiplexed sweep of
// N_NEUR leaky integrate-and-fire neurons (two cycles per neuron).
// Optional macro LIF_SCHED_REFRACT_EN adds a one-sweep refractory period per neuron.
module lif_scheduler #(
  parameter int unsigned N_NEUR = 4,
  parameter int unsigned W      = 8,
  parameter int unsigned DIV_W  = 22
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [DIV_W-1:0]      presc,
  input  logic [N_NEUR*W-1:0]   cur_in,
  input  logic [W-1:0]          thresh,
  input  logic [2:0]            leak_shift,
  input  logic                  ovr_clr,
  output logic [N_NEUR-1:0]     spike,
  output logic                  busy,
  output logic                  tick_ind,
  output logic                  overrun
);

  localparam int unsigned IDX_W = (N_NEUR > 1) ? $clog2(N_NEUR) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_NEUR - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;

  logic [1:0]       state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [DIV_W-1:0] cnt;
  logic             tick_c;
  logic             accept_c;
  logic             drop_c;

  logic [W-1:0]     u_mem [N_NEUR];
  logic [W-1:0]     u_hold;
  logic [W-1:0]     i_hold;
  logic [W-1:0]     u_sel_c;
  logic [W-1:0]     cur_sel_c;
  logic [W:0]       u_sum_c;
  logic [W-1:0]     u_new_c;
  logic [W-1:0]     u_store_c;
  logic             spk_c;

`ifdef LIF_SCHED_REFRACT_EN
  logic [N_NEUR-1:0] refr;
  logic              refr_sel_c;
`endif

  // Tick when the enabled counter reaches presc; counter wraps freely if presc drops below it.
  assign tick_c = en && (cnt == presc);

  // Prescaler counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (tick_c) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + DIV_W'(1);
    end
  end

  // Sweep state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Next-state logic; ticks outside IDLE are dropped and flagged.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    accept_c  = 1'b0;
    drop_c    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (tick_c) begin
          accept_c  = 1'b1;
          state_nxt = ST_FETCH;
          idx_nxt   = '0;
        end
      end
      ST_FETCH: begin
        state_nxt = ST_WRITE;
      end
      ST_WRITE: begin
        if (idx == IDX_LAST) begin
          state_nxt = ST_IDLE;
        end else begin
          idx_nxt   = idx + IDX_W'(1);
          state_nxt = ST_FETCH;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
    if (tick_c && (state != ST_IDLE)) begin
      drop_c = 1'b1;
    end
  end

  // Status outputs: busy follows the next state, tick_ind toggles per accepted tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      tick_ind <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      busy <= (state_nxt != ST_IDLE);
      if (accept_c) begin
        tick_ind <= ~tick_ind;
      end
      if (drop_c) begin
        overrun <= 1'b1;
      end else if (ovr_clr) begin
        overrun <= 1'b0;
      end
    end
  end

  // Select the current neuron's membrane value and input current.
  always_comb begin
    u_sel_c   = '0;
    cur_sel_c = '0;
    for (int k = 0; k < int'(N_NEUR); k++) begin
      if (idx == IDX_W'(k)) begin
        u_sel_c   = u_mem[k];
        cur_sel_c = cur_in[k*W +: W];
      end
    end
  end

`ifdef LIF_SCHED_REFRACT_EN
  // Refractory flag of the current neuron.
  always_comb begin
    refr_sel_c = 1'b0;
    for (int k = 0; k < int'(N_NEUR); k++) begin
      if (idx == IDX_W'(k)) begin
        refr_sel_c = refr[k];
      end
    end
  end
`endif

  // Leak, integrate and saturate in W+1 bits, then apply the threshold.
  always_comb begin
    u_sum_c   = {1'b0, u_hold} - {1'b0, (u_hold >> leak_shift)} + {1'b0, i_hold};
    u_new_c   = u_sum_c[W] ? {W{1'b1}} : u_sum_c[W-1:0];
    spk_c     = (u_new_c >= thresh);
    u_store_c = spk_c ? '0 : u_new_c;
`ifdef LIF_SCHED_REFRACT_EN
    if (refr_sel_c) begin
      spk_c     = 1'b0;
      u_store_c = '0;
    end
`endif
  end

  // Membrane storage, holding registers and per-neuron spike outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < int'(N_NEUR); k++) begin
        u_mem[k] <= '0;
      end
      u_hold <= '0;
      i_hold <= '0;
      spike  <= '0;
`ifdef LIF_SCHED_REFRACT_EN
      refr   <= '0;
`endif
    end else begin
      if (state == ST_FETCH) begin
        u_hold <= u_sel_c;
        i_hold <= cur_sel_c;
      end
      if (state == ST_WRITE) begin
        for (int k = 0; k < int'(N_NEUR); k++) begin
          if (idx == IDX_W'(k)) begin
            u_mem[k] <= u_store_c;
            spike[k] <= spk_c;
`ifdef LIF_SCHED_REFRACT_EN
            refr[k]  <= spk_c;
`endif
          end
        end
      end
    end
  end

endmodule
